// File: rtl/timer_seq_pkg.sv
// Shared types and frame constants for the timer command sequencer.
// The frame format is fixed by the timer: a 4-bit start pattern followed by a 4-bit delay.
package timer_seq_pkg;
    localparam int DELAY_W = 4;
    localparam int FRAME_LEN = 8;
    localparam logic [3:0] TIMER_PATTERN = 4'b1101;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_DONE,
        ACK
    } state_t;
endpackage

// File: rtl/timer_cmd_sequencer_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant and index from the request vector,
// searched from the pointer upward; the pointer moves past the winner only on advance.
module rr_arbiter #(
    parameter int N = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic             any,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;

    // First set request at or after the pointer, wrapping around the vector.
    always_comb begin
        int j;
        j = 0;
        any = 1'b0;
        grant_oh = '0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/timer_cmd_sequencer.sv
// Shares one serial-programmed one-shot timer among N_REQ requesters: arbitrates,
// shifts out the frame, watches the timer status, acks it and reports completion.
module timer_cmd_sequencer
    import timer_seq_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int START_TIMEOUT = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DELAY_W-1:0]   req_delay,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_id,
    output logic [N_REQ-1:0]           cmpl,
    output logic                       cmpl_err,
    output logic                       timer_data,
    output logic                       timer_ack,
    input  logic                       timer_counting,
    input  logic                       timer_done
);

    localparam int WD_W = $clog2(START_TIMEOUT + 1);
    localparam int CNT_W = $clog2(FRAME_LEN);

    state_t                 state;
    logic [FRAME_LEN-1:0]   shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WD_W-1:0]        wdog;
    logic [N_REQ-1:0]       owner_oh;

    logic                   arb_any;
    logic [N_REQ-1:0]       arb_oh;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_advance;
    logic [DELAY_W-1:0]     sel_delay;

    assign arb_advance = (state == IDLE);
    assign sel_delay = req_delay[arb_idx*DELAY_W +: DELAY_W];

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .advance   (arb_advance),
        .any       (arb_any),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    // The first frame bit is loaded at grant so it appears in the first SEND cycle;
    // a timeout also passes through ACK so cmpl always lands while busy is still high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            grant_id   <= '0;
            owner_oh   <= '0;
            cmpl       <= '0;
            cmpl_err   <= 1'b0;
            timer_data <= 1'b0;
            timer_ack  <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            wdog       <= '0;
        end else begin
            cmpl      <= '0;
            cmpl_err  <= 1'b0;
            timer_ack <= 1'b0;
            case (state)
                IDLE: begin
                    timer_data <= 1'b0;
                    if (arb_any) begin
                        state      <= SEND;
                        busy       <= 1'b1;
                        grant_id   <= arb_idx;
                        owner_oh   <= arb_oh;
                        timer_data <= TIMER_PATTERN[3];
                        shreg      <= {TIMER_PATTERN[2:0], sel_delay, 1'b0};
                        bit_cnt    <= '0;
                    end
                end
                SEND: begin
                    if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        state      <= WAIT_START;
                        timer_data <= 1'b0;
                        wdog       <= '0;
                    end else begin
                        timer_data <= shreg[FRAME_LEN-1];
                        shreg      <= {shreg[FRAME_LEN-2:0], 1'b0};
                        bit_cnt    <= bit_cnt + 1'b1;
                    end
                end
                WAIT_START: begin
                    if (timer_counting) begin
                        state <= WAIT_DONE;
                    end else if (timer_done) begin
                        state     <= ACK;
                        timer_ack <= 1'b1;
                        cmpl      <= owner_oh;
                    end else if (wdog == WD_W'(START_TIMEOUT - 1)) begin
                        state    <= ACK;
                        cmpl     <= owner_oh;
                        cmpl_err <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (timer_done) begin
                        state     <= ACK;
                        timer_ack <= 1'b1;
                        cmpl      <= owner_oh;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Self-checking bench for timer_cmd_sequencer with a behavioural model of the one-shot timer
// (detects 1101 + 4-bit delay, counts (delay+1)*1000 cycles, holds done until ack).
module tb_timer_cmd_sequencer;

    localparam int N = 2;
    localparam int IW = 1;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*4-1:0]   req_delay;
    logic             busy;
    logic [IW-1:0]    grant_id;
    logic [N-1:0]     cmpl;
    logic             cmpl_err;
    logic             timer_data;
    logic             timer_ack;
    logic             timer_counting;
    logic             timer_done;

    int total = 0;
    int bad = 0;
    logic stub_mode;

    typedef struct {
        bit          found;
        int          wait_cyc;
        logic [IW-1:0] gid;
        logic [7:0]  frame;
        int          lat;
        int          cnt;
        int          done_at;
        int          acks;
        logic [N-1:0] cvec;
        logic        cerr;
        logic        ack_cmpl;
        logic        busy_cmpl;
        logic        busy_after;
        logic        data_after;
    } job_obs_t;

    timer_cmd_sequencer #(
        .N_REQ         (N),
        .START_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_delay      (req_delay),
        .busy           (busy),
        .grant_id       (grant_id),
        .cmpl           (cmpl),
        .cmpl_err       (cmpl_err),
        .timer_data     (timer_data),
        .timer_ack      (timer_ack),
        .timer_counting (timer_counting),
        .timer_done     (timer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural timer: hunt for the start pattern, collect four delay bits, count, then hold done.
    int         t_state;
    logic [3:0] t_hist;
    logic [3:0] t_dly;
    int         t_bits;
    int         t_cnt;

    always @(posedge clk) begin
        if (reset || stub_mode) begin
            t_state <= 0;
            t_hist <= 4'd0;
            t_dly <= 4'd0;
            t_bits <= 0;
            t_cnt <= 0;
            timer_counting <= 1'b0;
            timer_done <= 1'b0;
        end else begin
            case (t_state)
                0: begin
                    t_hist <= {t_hist[2:0], timer_data};
                    if ({t_hist[2:0], timer_data} == 4'b1101) begin
                        t_state <= 1;
                        t_bits <= 0;
                    end
                end
                1: begin
                    t_dly <= {t_dly[2:0], timer_data};
                    t_bits <= t_bits + 1;
                    if (t_bits == 3) begin
                        t_state <= 2;
                        t_cnt <= (int'({t_dly[2:0], timer_data}) + 1) * 1000;
                        timer_counting <= 1'b1;
                    end
                end
                2: begin
                    if (t_cnt == 1) begin
                        timer_counting <= 1'b0;
                        timer_done <= 1'b1;
                        t_state <= 3;
                    end else begin
                        t_cnt <= t_cnt - 1;
                    end
                end
                default: begin
                    if (timer_ack) begin
                        timer_done <= 1'b0;
                        t_hist <= 4'd0;
                        t_state <= 0;
                    end
                end
            endcase
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        req_delay = '0;
        stub_mode = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Observes one job from grant to the cycle after completion; gathers values only.
    task automatic watch_job(output job_obs_t o);
        int w;
        int n;
        o.found = 0; o.wait_cyc = 0; o.gid = '0; o.frame = '0; o.lat = -1; o.cnt = 0;
        o.done_at = -1; o.acks = 0; o.cvec = '0; o.cerr = 0; o.ack_cmpl = 0;
        o.busy_cmpl = 0; o.busy_after = 1; o.data_after = 1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!busy && w < 50);
        o.wait_cyc = w;
        if (!busy) return;
        o.found = 1;
        o.gid = grant_id;
        for (int k = 0; k < 8; k++) begin
            o.frame[7-k] = timer_data;
            if (timer_ack) o.acks++;
            @(negedge clk);
        end
        n = 8;
        while (n < 20000 && cmpl == '0) begin
            if (timer_counting) o.cnt++;
            if (timer_done && o.done_at < 0) o.done_at = n;
            if (timer_ack) o.acks++;
            @(negedge clk);
            n++;
        end
        if (cmpl == '0) return;
        o.lat = n;
        o.cvec = cmpl;
        o.cerr = cmpl_err;
        o.ack_cmpl = timer_ack;
        o.busy_cmpl = busy;
        if (timer_ack) o.acks++;
        @(negedge clk);
        o.busy_after = busy;
        o.data_after = timer_data;
        if (timer_ack) o.acks++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '0;
        req_delay = '0;
        stub_mode = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, grant_id, cmpl, cmpl_err, timer_data, timer_ack} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b want=0", {busy, grant_id, cmpl, cmpl_err, timer_data, timer_ack});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_single();
        job_obs_t o;
        do_reset();
        req_delay[3:0] = 4'd1;
        req = 2'b01;
        watch_job(o);
        req = 2'b00;
        total++;
        if (!o.found || o.lat < 0) begin bad++; $display("[TB] FAIL t1_timeout found=%0d lat=%0d want completion", o.found, o.lat); end
        total++;
        if (o.frame !== 8'b1101_0001) begin bad++; $display("[TB] FAIL t1_frame got=%b want=11010001", o.frame); end
        total++;
        if (o.cnt != 2000) begin bad++; $display("[TB] FAIL t1_count got=%0d want=2000", o.cnt); end
        total++;
        if (o.lat != o.done_at + 1) begin bad++; $display("[TB] FAIL t1_ack_latency got=%0d want=%0d", o.lat, o.done_at + 1); end
        total++;
        if ({o.cvec, o.cerr, o.ack_cmpl, o.busy_cmpl} !== 5'b01_0_1_1) begin
            bad++; $display("[TB] FAIL t1_cmpl got=%b want=01011", {o.cvec, o.cerr, o.ack_cmpl, o.busy_cmpl});
        end
        total++;
        if (o.acks != 1 || o.busy_after !== 1'b0) begin
            bad++; $display("[TB] FAIL t1_ack_busy acks=%0d busy_after=%b want 1 and 0", o.acks, o.busy_after);
        end
    endtask

    task automatic test_back_to_back();
        job_obs_t o1;
        job_obs_t o2;
        do_reset();
        req_delay = {4'd2, 4'd0};
        req = 2'b11;
        watch_job(o1);
        req[0] = 1'b0;
        watch_job(o2);
        req = 2'b00;
        total++;
        if (o1.gid !== 1'd0 || o1.frame !== 8'b1101_0000 || o1.cnt != 1000 || o1.cvec !== 2'b01) begin
            bad++; $display("[TB] FAIL t2_job0 gid=%0d frame=%b cnt=%0d cmpl=%b want 0/11010000/1000/01", o1.gid, o1.frame, o1.cnt, o1.cvec);
        end
        total++;
        if (o1.busy_after !== 1'b0 || o1.data_after !== 1'b0 || o2.wait_cyc != 1) begin
            bad++; $display("[TB] FAIL t2_gap busy=%b data=%b gap=%0d want 0/0/1", o1.busy_after, o1.data_after, o2.wait_cyc);
        end
        total++;
        if (o2.gid !== 1'd1 || o2.frame !== 8'b1101_0010 || o2.cnt != 3000 || o2.cvec !== 2'b10) begin
            bad++; $display("[TB] FAIL t2_job1 gid=%0d frame=%b cnt=%0d cmpl=%b want 1/11010010/3000/10", o2.gid, o2.frame, o2.cnt, o2.cvec);
        end
    endtask

    task automatic test_round_robin();
        job_obs_t o1;
        job_obs_t o2;
        job_obs_t o3;
        do_reset();
        req_delay = '0;
        req = 2'b01;
        fork
            watch_job(o1);
            begin
                repeat (5) @(negedge clk);
                req[1] = 1'b1;
            end
        join
        watch_job(o2);
        req[1] = 1'b0;
        watch_job(o3);
        req = 2'b00;
        total++;
        if ({o1.gid, o2.gid, o3.gid} !== 3'b010) begin
            bad++; $display("[TB] FAIL t3_order got=%b want=010", {o1.gid, o2.gid, o3.gid});
        end
        total++;
        if ({o1.cvec, o2.cvec, o3.cvec} !== 6'b01_10_01) begin
            bad++; $display("[TB] FAIL t3_cmpl got=%b want=011001", {o1.cvec, o2.cvec, o3.cvec});
        end
    endtask

    task automatic test_start_timeout();
        job_obs_t o;
        do_reset();
        stub_mode = 1'b1;
        req_delay[3:0] = 4'd3;
        req = 2'b01;
        watch_job(o);
        req = 2'b00;
        stub_mode = 1'b0;
        total++;
        if (o.frame !== 8'b1101_0011 || o.lat != 12) begin
            bad++; $display("[TB] FAIL t4_timing frame=%b lat=%0d want 11010011/12", o.frame, o.lat);
        end
        total++;
        if (o.cvec !== 2'b01 || o.cerr !== 1'b1 || o.acks != 0) begin
            bad++; $display("[TB] FAIL t4_err cmpl=%b err=%b acks=%0d want 01/1/0", o.cvec, o.cerr, o.acks);
        end
        total++;
        if (o.busy_cmpl !== 1'b1 || o.busy_after !== 1'b0) begin
            bad++; $display("[TB] FAIL t4_busy at_cmpl=%b after=%b want 1/0", o.busy_cmpl, o.busy_after);
        end
    endtask

    task automatic test_reset_abort();
        job_obs_t o;
        int seen;
        do_reset();
        req_delay[3:0] = 4'd5;
        req = 2'b01;
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        total++;
        if (!busy) begin bad++; $display("[TB] FAIL t5_grant busy=%b want=1", busy); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req = 2'b00;
        @(negedge clk);
        total++;
        if ({busy, grant_id, cmpl, cmpl_err, timer_data, timer_ack} !== '0) begin
            bad++; $display("[TB] FAIL t5_abort got=%b want=0", {busy, grant_id, cmpl, cmpl_err, timer_data, timer_ack});
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmpl != '0 || busy || timer_ack) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("[TB] FAIL t5_no_cmpl got=%0d want=0", seen); end
        req_delay[3:0] = 4'd15;
        req = 2'b01;
        watch_job(o);
        req = 2'b00;
        total++;
        if (o.frame !== 8'b1101_1111 || o.cnt != 16000 || o.cvec !== 2'b01 || o.cerr !== 1'b0) begin
            bad++; $display("[TB] FAIL t5_job frame=%b cnt=%0d cmpl=%b err=%b want 11011111/16000/01/0", o.frame, o.cnt, o.cvec, o.cerr);
        end
    endtask

    task automatic test_delay_latch();
        job_obs_t o;
        do_reset();
        req_delay[3:0] = 4'd1;
        req = 2'b01;
        fork
            watch_job(o);
            begin
                repeat (3) @(negedge clk);
                req_delay[3:0] = 4'd7;
            end
        join
        req = 2'b00;
        total++;
        if (o.frame !== 8'b1101_0001 || o.cnt != 2000) begin
            bad++; $display("[TB] FAIL t6_latch frame=%b cnt=%0d want 11010001/2000", o.frame, o.cnt);
        end
    endtask

    // Random arrivals checked against a round-robin reference: the pointer sits just past the last winner.
    task automatic test_random();
        job_obs_t o;
        bit pending [N];
        logic [3:0] dly [N];
        int ptr;
        int win;
        int c;
        logic [N-1:0] eoh;
        logic [7:0] ef;
        do_reset();
        ptr = 0;
        for (int i = 0; i < N; i++) begin pending[i] = 0; dly[i] = 4'd0; end
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1;
                    dly[i] = 4'($urandom_range(0, 2));
                end
            end
            if (!pending[0] && !pending[1]) begin
                c = int'($urandom_range(0, N - 1));
                pending[c] = 1;
                dly[c] = 4'($urandom_range(0, 2));
            end
            for (int i = 0; i < N; i++) begin
                req[i] = pending[i];
                req_delay[i*4 +: 4] = dly[i];
            end
            win = -1;
            for (int k = 0; k < N; k++) begin
                c = (ptr + k) % N;
                if (win < 0 && pending[c]) win = c;
            end
            watch_job(o);
            eoh = '0;
            eoh[win] = 1'b1;
            ef = {4'b1101, dly[win]};
            total++;
            if (int'(o.gid) != win || o.cvec !== eoh || o.cerr !== 1'b0) begin
                bad++; $display("[TB] FAIL rnd%0d_grant gid=%0d cmpl=%b err=%b want %0d/%b/0", r, o.gid, o.cvec, o.cerr, win, eoh);
            end
            total++;
            if (o.frame !== ef || o.cnt != (int'(dly[win]) + 1) * 1000) begin
                bad++; $display("[TB] FAIL rnd%0d_frame frame=%b cnt=%0d want %b/%0d", r, o.frame, o.cnt, ef, (int'(dly[win]) + 1) * 1000);
            end
            pending[win] = 0;
            req[win] = 1'b0;
            ptr = (win + 1) % N;
        end
        req = '0;
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        reset = 1'b1;
        req = '0;
        req_delay = '0;
        stub_mode = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_start_timeout();
        test_reset_abort();
        test_delay_latch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
